// File: rtl/axi_pkg.sv
// AXI read-channel shared types and encodings for the responder slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: burst/resp encodings, responder FSM state, AR request and R beat structs.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Default channel widths for the struct views below.
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_RESP_W = 2;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } rsp_state_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_req_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_RESP_W-1:0] resp;
    logic                  last;
  } r_beat_t;

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Next-beat address and burst error flag for an AXI read burst.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume next_addr.
// Ports: addr/size/burst of the current beat in; next_addr and err (WRAP/reserved
// burst, or size wider than the data bus) out.
module axi_beat_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

  always_comb begin
    next_addr = addr;
    // Only INCR advances; FIXED holds, and unsupported WRAP/reserved are held fixed too.
    // Overflow past the top of the address space wraps silently.
    if (burst == BURST_INCR) begin
      next_addr = addr + (ADDR_WIDTH'(1) << size);
    end
    err = burst[1] || (int'(size) > MAX_SIZE);
  end

endmodule

// File: rtl/r_burst_responder.sv
// Slave-side AXI read responder: accepts one AR, waits LATENCY cycles, emits len+1 R beats.
// Latency: AR handshake in cycle T -> first R valid in cycle T+1+LATENCY; then 1 beat/cycle.
// Backpressure: R beats held stable while r_out_ready is low; AR accepted only when idle.
// Ports: clk, rst_n (async active-low); ar_in_* AR receiver (valid/ready/id/addr/len/size/burst);
// r_out_* R sender (valid/ready/id/data/resp/last). R data is the beat address, zero-extended.
module r_burst_responder
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int LEN_WIDTH  = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  ar_in_valid,
  output logic                  ar_in_ready,
  input  logic [ID_WIDTH-1:0]   ar_in_id,
  input  logic [ADDR_WIDTH-1:0] ar_in_addr,
  input  logic [LEN_WIDTH-1:0]  ar_in_len,
  input  logic [2:0]            ar_in_size,
  input  logic [1:0]            ar_in_burst,

  output logic                  r_out_valid,
  input  logic                  r_out_ready,
  output logic [ID_WIDTH-1:0]   r_out_id,
  output logic [DATA_WIDTH-1:0] r_out_data,
  output logic [RESP_WIDTH-1:0] r_out_resp,
  output logic                  r_out_last
);

  localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  rsp_state_t st, st_nxt;
  logic       ar_rdy_q;

  logic [LAT_W-1:0]      lat_cnt;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;

  logic ar_hs, r_hs, beat_last;

  logic [ADDR_WIDTH-1:0] gen_addr, next_addr, load_addr;
  logic [2:0]            gen_size;
  logic [1:0]            gen_burst;
  logic                  gen_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_beat;

  logic                  r_valid_d;
  logic [ID_WIDTH-1:0]   r_id_d;
  logic [RESP_WIDTH-1:0] r_resp_d;
  logic                  r_last_d;

  assign ar_in_ready = ar_rdy_q;
  assign ar_hs       = ar_in_valid & ar_rdy_q;
  assign r_hs        = r_out_valid & r_out_ready;
  assign beat_last   = (beat_cnt == len_q);

  // While idle the generator looks at the incoming AR, so a LATENCY=0 build can
  // present the first beat straight from the handshake; otherwise it follows the
  // captured burst.
  assign gen_addr  = (st == ST_IDLE) ? ar_in_addr  : addr_q;
  assign gen_size  = (st == ST_IDLE) ? ar_in_size  : size_q;
  assign gen_burst = (st == ST_IDLE) ? ar_in_burst : burst_q;

  axi_beat_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_addr_gen (
    .addr      (gen_addr),
    .size      (gen_size),
    .burst     (gen_burst),
    .next_addr (next_addr),
    .err       (gen_err)
  );

  if (DATA_WIDTH > ADDR_WIDTH) begin : g_zext
    assign load_data = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, load_addr};
  end else begin : g_trunc
    assign load_data = load_addr[DATA_WIDTH-1:0];
  end

  // State register. ar_rdy_q mirrors (st == ST_IDLE) but is a flop of its own so
  // that it reads 0 throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      ar_rdy_q <= 1'b0;
    end else begin
      st       <= st_nxt;
      ar_rdy_q <= (st_nxt == ST_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (ar_hs) st_nxt = (LATENCY > 0) ? ST_WAIT : ST_SEND;
      ST_WAIT: if (lat_cnt == LAT_W'(1)) st_nxt = ST_SEND;
      ST_SEND: if (r_hs && beat_last) st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Captured request and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt  <= '0;
      beat_cnt <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
    end else if (ar_hs) begin
      id_q     <= ar_in_id;
      addr_q   <= ar_in_addr;
      len_q    <= ar_in_len;
      size_q   <= ar_in_size;
      burst_q  <= ar_in_burst;
      beat_cnt <= '0;
      lat_cnt  <= LAT_W'(LATENCY);
    end else if (st == ST_WAIT) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end else if (st == ST_SEND && r_hs && !beat_last) begin
      beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      addr_q   <= next_addr;
    end
  end

  // Output logic: next values for the registered R channel. Fields only change
  // when a new beat is loaded, so they hold still across stalls.
  always_comb begin
    r_valid_d = r_out_valid;
    r_id_d    = r_out_id;
    r_resp_d  = r_out_resp;
    r_last_d  = r_out_last;
    load_addr = next_addr;
    load_beat = 1'b0;
    if (st != ST_SEND && st_nxt == ST_SEND) begin
      // First beat of a burst; resp is fixed for the whole burst from here on.
      load_beat = 1'b1;
      r_valid_d = 1'b1;
      r_id_d    = (st == ST_IDLE) ? ar_in_id : id_q;
      load_addr = gen_addr;
      r_resp_d  = gen_err ? RESP_WIDTH'(RESP_SLVERR) : RESP_WIDTH'(RESP_OKAY);
      r_last_d  = (((st == ST_IDLE) ? ar_in_len : len_q) == '0);
    end else if (st == ST_SEND && r_hs) begin
      if (beat_last) begin
        r_valid_d = 1'b0;
      end else begin
        load_beat = 1'b1;
        load_addr = next_addr;
        r_last_d  = ((beat_cnt + LEN_WIDTH'(1)) == len_q);
      end
    end
  end

  // Asynchronous reset pulls valid low at once, abandoning any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
      r_out_resp  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= r_valid_d;
      r_out_id    <= r_id_d;
      r_out_resp  <= r_resp_d;
      r_out_last  <= r_last_d;
      if (load_beat) r_out_data <= load_data;
    end
  end

endmodule

// File: tb/tb_r_burst_responder.sv
module tb_r_burst_responder;
  import axi_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk;
  logic rst_n;

  logic        a_ar_valid, a_ar_ready, a_r_valid, a_r_ready, a_r_last;
  logic [3:0]  a_ar_id, a_r_id;
  logic [31:0] a_ar_addr;
  logic [7:0]  a_ar_len;
  logic [2:0]  a_ar_size;
  logic [1:0]  a_ar_burst, a_r_resp;
  logic [63:0] a_r_data;

  logic        b_ar_valid, b_ar_ready, b_r_valid, b_r_ready, b_r_last;
  logic [3:0]  b_ar_id, b_r_id;
  logic [31:0] b_ar_addr;
  logic [7:0]  b_ar_len;
  logic [2:0]  b_ar_size;
  logic [1:0]  b_ar_burst, b_r_resp;
  logic [63:0] b_r_data;

  r_burst_responder #(.LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ar_in_valid(a_ar_valid), .ar_in_ready(a_ar_ready), .ar_in_id(a_ar_id),
    .ar_in_addr(a_ar_addr), .ar_in_len(a_ar_len), .ar_in_size(a_ar_size),
    .ar_in_burst(a_ar_burst),
    .r_out_valid(a_r_valid), .r_out_ready(a_r_ready), .r_out_id(a_r_id),
    .r_out_data(a_r_data), .r_out_resp(a_r_resp), .r_out_last(a_r_last)
  );

  r_burst_responder #(.LATENCY(LAT_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ar_in_valid(b_ar_valid), .ar_in_ready(b_ar_ready), .ar_in_id(b_ar_id),
    .ar_in_addr(b_ar_addr), .ar_in_len(b_ar_len), .ar_in_size(b_ar_size),
    .ar_in_burst(b_ar_burst),
    .r_out_valid(b_r_valid), .r_out_ready(b_r_ready), .r_out_id(b_r_id),
    .r_out_data(b_r_data), .r_out_resp(b_r_resp), .r_out_last(b_r_last)
  );

  r_beat_t a_obs, b_obs;
  assign a_obs = {a_r_id, a_r_data, a_r_resp, a_r_last};
  assign b_obs = {b_r_id, b_r_data, b_r_resp, b_r_last};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  r_beat_t qa[$];
  r_beat_t qb[$];

  bit      pv[2];
  bit      pr[2];
  bit      pend_last[2];
  r_beat_t pobs[2];
  int      hs_cnt[2];

  int mode_a = 0;
  int mode_b = 0;
  int ptn = 0;

  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d got=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference model: beat list straight from the burst rules.
  task automatic push_expected(input int k, input logic [3:0] id, input logic [31:0] addr,
                               input int len, input int size, input logic [1:0] burst);
    logic [31:0] a;
    bit err;
    r_beat_t b;
    a = addr;
    err = (burst > 2'd1) || (size > 3);
    for (int i = 0; i <= len; i++) begin
      b.id   = id;
      b.data = {32'd0, a};
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == len);
      if (k == 0) qa.push_back(b); else qb.push_back(b);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic rdy, input r_beat_t obs, input logic arr);
    r_beat_t e;
    bit empty;
    if (!rst_n) begin
      pv[k] = 1'b0;
      pr[k] = 1'b0;
      pend_last[k] = 1'b0;
      return;
    end
    if (pend_last[k]) begin
      chk("ar_ready_after_last", k, arr, 1);
      chk("valid_low_after_last", k, v, 0);
      pend_last[k] = 1'b0;
    end
    if (pv[k] && !pr[k]) begin
      chk("stall_valid_held", k, v, 1);
      chk("stall_beat_stable", k, obs, pobs[k]);
    end
    if (v) chk("ar_ready_low_busy", k, arr, 0);
    if (v && rdy) begin
      empty = (k == 0) ? (qa.size() == 0) : (qb.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat dut=%0d got=%0h expected=none", k, obs);
      end else begin
        e = (k == 0) ? qa.pop_front() : qb.pop_front();
        chk("beat", k, obs, e);
        hs_cnt[k]++;
        if (e.last) pend_last[k] = 1'b1;
      end
    end
    pv[k] = v;
    pr[k] = rdy;
    pobs[k] = obs;
  endtask

  always @(negedge clk) begin
    mon(0, a_r_valid, a_r_ready, a_obs, a_ar_ready);
    mon(1, b_r_valid, b_r_ready, b_obs, b_ar_ready);
  end

  function automatic logic pick(input int mode, input int p);
    if (mode == 1) return logic'($urandom_range(0, 1));
    if (mode == 2) return (p % 3 == 0);
    return 1'b1;
  endfunction

  initial begin
    a_r_ready = 1'b1;
    b_r_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ptn++;
      a_r_ready = pick(mode_a, ptn);
      b_r_ready = pick(mode_b, ptn);
    end
  end

  task automatic issue(input int k, input logic [3:0] id, input logic [31:0] addr,
                       input int len, input int size, input logic [1:0] burst);
    int n;
    bit got;
    logic rdy, vld;
    @(posedge clk);
    #1;
    push_expected(k, id, addr, len, size, burst);
    if (k == 0) begin
      a_ar_id = id; a_ar_addr = addr; a_ar_len = 8'(len); a_ar_size = 3'(size);
      a_ar_burst = burst; a_ar_valid = 1'b1;
    end else begin
      b_ar_id = id; b_ar_addr = addr; b_ar_len = 8'(len); b_ar_size = 3'(size);
      b_ar_burst = burst; b_ar_valid = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 3000) begin
      @(negedge clk);
      rdy = (k == 0) ? a_ar_ready : b_ar_ready;
      if (rdy) got = 1'b1;
      n++;
    end
    chk("ar_accept_timeout", k, got, 1);
    @(posedge clk);
    #1;
    if (k == 0) begin a_ar_valid = 1'b0; a_ar_addr = $urandom; a_ar_id = 4'($urandom); end
    else begin b_ar_valid = 1'b0; b_ar_addr = $urandom; b_ar_id = 4'($urandom); end
    n = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      vld = (k == 0) ? a_r_valid : b_r_valid;
      if (vld) got = 1'b1;
    end
    chk("first_valid_latency", k, n, 1 + ((k == 0) ? LAT_A : LAT_B));
  endtask

  task automatic wait_drain(input int k);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      done = (k == 0) ? (qa.size() == 0 && a_ar_ready) : (qb.size() == 0 && b_ar_ready);
    end
    chk("drain", k, done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, k, len, size;
    logic [31:0] addr;
    rst_n = 1'b0;
    a_ar_valid = 0; a_ar_id = 0; a_ar_addr = 0; a_ar_len = 0; a_ar_size = 0; a_ar_burst = 0;
    b_ar_valid = 0; b_ar_id = 0; b_ar_addr = 0; b_ar_len = 0; b_ar_size = 0; b_ar_burst = 0;
    #12;
    chk("reset_ar_ready", 0, a_ar_ready, 0);
    chk("reset_r_valid", 0, a_r_valid, 0);
    chk("reset_r_fields", 0, a_obs, 0);
    chk("reset_ar_ready", 1, b_ar_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ar_ready", 0, a_ar_ready, 1);
    chk("post_reset_ar_ready", 1, b_ar_ready, 1);
    chk("post_reset_r_valid", 0, a_r_valid, 0);

    // Basic INCR burst, always ready.
    mode_a = 0;
    issue(0, 4'd3, 32'h100, 3, 3, 2'b01);
    wait_drain(0);

    // Same burst under a 1,0,0 ready pattern: exactly four handshakes.
    mode_a = 2;
    h0 = hs_cnt[0];
    issue(0, 4'd3, 32'h100, 3, 3, 2'b01);
    wait_drain(0);
    chk("stall_handshake_count", 0, hs_cnt[0] - h0, 4);
    mode_a = 0;

    // Zero-latency build, single FIXED beat.
    mode_b = 0;
    issue(1, 4'd5, 32'h40, 0, 3, 2'b00);
    wait_drain(1);

    // Error bursts: WRAP, and oversize beat.
    issue(0, 4'd7, 32'h200, 1, 3, 2'b10);
    wait_drain(0);
    issue(0, 4'd8, 32'h300, 1, 4, 2'b01);
    wait_drain(0);

    // Address wrap at the top of the space.
    issue(0, 4'd1, 32'hFFFF_FFF8, 1, 3, 2'b01);
    wait_drain(0);

    // Reset during beat 2 of an 8-beat burst.
    issue(0, 4'd2, 32'h1000, 7, 3, 2'b01);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midburst_reset_valid", 0, a_r_valid, 0);
    chk("midburst_reset_ar_ready", 0, a_ar_ready, 0);
    qa.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_ar_ready", 0, a_ar_ready, 1);
    chk("rerelease_r_valid", 0, a_r_valid, 0);
    issue(0, 4'd9, 32'h2000, 3, 2, 2'b01);
    wait_drain(0);

    // Randomized traffic across both builds.
    for (int n = 0; n < 40; n++) begin
      k = (n % 4 == 3) ? 1 : 0;
      if (k == 0) mode_a = $urandom_range(0, 2); else mode_b = $urandom_range(0, 2);
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3F)) : $urandom;
      len  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      size = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      issue(k, 4'($urandom), addr, len, size, 2'($urandom_range(0, 3)));
    end
    wait_drain(0);
    wait_drain(1);
    chk("queue_a_empty", 0, qa.size(), 0);
    chk("queue_b_empty", 1, qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
